ofm_drain_scheduler: RTL and testbench

- Sequences the drain of finished partial sums from the SYSTOLIC_SIZE x SYSTOLIC_SIZE PE array into the output feature-map RAM, one array row (SYSTOLIC_SIZE words wide) per cycle.
- Tracks the tile index and filter group, generates OFM RAM addresses, applies RAM backpressure, and suppresses writes for padding rows of the last partial tile.
- Sits between the main controller (drain requests), the PE array (shift-out) and the OFM RAM write port.

---
 rtl/ofm_drain_scheduler_pkg.sv | 17 +
 rtl/ofm_addr_gen.sv | 75 +++++++
 rtl/ofm_drain_scheduler.sv | 109 ++++++++++
 tb/tb_ofm_drain_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofm_drain_scheduler_pkg.sv
// Shared types and sizing helpers for the OFM drain path.
// The PE array and main controller use the same defaults.
package ofm_drain_scheduler_pkg;

  localparam int unsigned SYSTOLIC_SIZE_DEF = 16;
  localparam int unsigned PSUM_WIDTH_DEF    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Row/tile/filter-group counters and the OFM RAM word-row address.
// The counters step on every array shift; SYSTOLIC_SIZE must be a power of two.
module ofm_addr_gen
  import ofm_drain_scheduler_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
  parameter int unsigned NO_FILTER     = 16,
  parameter int unsigned OFM_PIXELS    = 10765,
  parameter int unsigned ADDR_WIDTH    = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_adv,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_row_real,
  output logic                  o_last_row,
  output logic                  o_last_tile_of_layer
);

  localparam int unsigned NO_TILE   = ceil_div(OFM_PIXELS, SYSTOLIC_SIZE);
  localparam int unsigned NO_FGROUP = ceil_div(NO_FILTER, SYSTOLIC_SIZE);
  localparam int unsigned ROW_W     = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int unsigned TILE_W    = (NO_TILE > 1) ? $clog2(NO_TILE) : 1;
  localparam int unsigned FG_W      = (NO_FGROUP > 1) ? $clog2(NO_FGROUP) : 1;
  localparam int unsigned PIX_W     = TILE_W + ROW_W;

  logic [ROW_W-1:0]      r_row;
  logic [TILE_W-1:0]     r_tile;
  logic [FG_W-1:0]       r_fgroup;
  logic [ADDR_WIDTH-1:0] r_fgroup_base;

  logic [PIX_W-1:0] w_pix;
  logic             w_last_tile;
  logic             w_last_fg;

  // tile*SYSTOLIC_SIZE + row is a plain bit concatenation
  assign w_pix       = {r_tile, r_row};
  assign w_last_tile = (r_tile == TILE_W'(NO_TILE - 1));
  assign w_last_fg   = (r_fgroup == FG_W'(NO_FGROUP - 1));

  assign o_last_row           = (r_row == ROW_W'(SYSTOLIC_SIZE - 1));
  assign o_last_tile_of_layer = w_last_tile && w_last_fg;
  assign o_row_real           = (32'(w_pix) < 32'(OFM_PIXELS));
  assign o_addr               = r_fgroup_base + ADDR_WIDTH'(w_pix);

  // fgroup*OFM_PIXELS kept as a running base instead of a multiplier
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_row         <= '0;
      r_tile        <= '0;
      r_fgroup      <= '0;
      r_fgroup_base <= '0;
    end else if (i_adv) begin
      if (o_last_row) begin
        r_row <= '0;
        if (w_last_tile) begin
          r_tile <= '0;
          if (w_last_fg) begin
            r_fgroup      <= '0;
            r_fgroup_base <= '0;
          end else begin
            r_fgroup      <= r_fgroup + FG_W'(1);
            r_fgroup_base <= r_fgroup_base + ADDR_WIDTH'(OFM_PIXELS);
          end
        end else begin
          r_tile <= r_tile + TILE_W'(1);
        end
      end else begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/ofm_drain_scheduler.sv
// Drains finished PE-array partial sums into the OFM RAM one row per cycle,
// with RAM backpressure, padding-row suppression and a one-deep request queue.
module ofm_drain_scheduler
  import ofm_drain_scheduler_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = SYSTOLIC_SIZE_DEF,
  parameter int unsigned NO_FILTER     = 16,
  parameter int unsigned OFM_PIXELS    = 10765,
  parameter int unsigned PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH    = 18
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_drain_start,
  input  logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] i_psum_in,
  output logic                                o_shift_out,
  input  logic                                i_wr_ready,
  output logic                                o_wr_valid,
  output logic [ADDR_WIDTH-1:0]               o_wr_addr,
  output logic [SYSTOLIC_SIZE*PSUM_WIDTH-1:0] o_wr_data,
  output logic                                o_busy,
  output logic                                o_tile_done,
  output logic                                o_layer_done,
  output logic                                o_overflow_err
);

  state_e r_state;
  logic   r_pending;
  logic   r_tile_done;
  logic   r_layer_done;
  logic   r_overflow_err;

  logic w_drain;
  logic w_row_real;
  logic w_last_row;
  logic w_last_layer;
  logic w_finish;
  logic w_clr;

  ofm_addr_gen #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .NO_FILTER     (NO_FILTER),
    .OFM_PIXELS    (OFM_PIXELS),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_addr_gen (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_clr                (w_clr),
    .i_adv                (o_shift_out),
    .o_addr               (o_wr_addr),
    .o_row_real           (w_row_real),
    .o_last_row           (w_last_row),
    .o_last_tile_of_layer (w_last_layer)
  );

  // Padding rows shift freely; real rows wait for the RAM
  assign w_drain     = (r_state == ST_DRAIN);
  assign o_shift_out = w_drain && (i_wr_ready || !w_row_real);
  assign o_wr_valid  = w_drain && w_row_real;
  assign o_wr_data   = o_wr_valid ? i_psum_in : '0;
  assign w_finish    = o_shift_out && w_last_row;
  assign w_clr       = i_start && (r_state == ST_IDLE) && !r_pending;

  assign o_busy         = w_drain || r_pending;
  assign o_tile_done    = r_tile_done;
  assign o_layer_done   = r_layer_done;
  assign o_overflow_err = r_overflow_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_pending      <= 1'b0;
      r_tile_done    <= 1'b0;
      r_layer_done   <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_tile_done  <= 1'b0;
      r_layer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_drain_start || r_pending) begin
            r_state   <= ST_DRAIN;
            r_pending <= r_pending && i_drain_start;
          end
        end
        ST_DRAIN: begin
          if (w_finish) begin
            // A queued or same-cycle request chains straight into the next tile
            r_tile_done  <= 1'b1;
            r_layer_done <= w_last_layer;
            if (!(r_pending || i_drain_start)) begin
              r_state <= ST_IDLE;
            end
            r_pending <= r_pending && i_drain_start;
          end else if (i_drain_start) begin
            if (r_pending) begin
              r_overflow_err <= 1'b1;
            end else begin
              r_pending <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_drain_scheduler.sv
// Bench for ofm_drain_scheduler: 16x16 array, 40 pixels, 32 filters
// (3 tiles per filter group, 2 filter groups).
module tb_ofm_drain_scheduler;

  localparam int unsigned SS  = 16;
  localparam int unsigned NF  = 32;
  localparam int unsigned OP  = 40;
  localparam int unsigned PW  = 16;
  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = SS * PW;
  localparam int          NT  = 3;
  localparam int          NFG = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          drain_start;
  logic [DW-1:0] psum_in;
  logic          shift_out;
  logic          wr_ready;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          tile_done;
  logic          layer_done;
  logic          overflow_err;

  ofm_drain_scheduler #(
    .SYSTOLIC_SIZE (SS),
    .NO_FILTER     (NF),
    .OFM_PIXELS    (OP),
    .PSUM_WIDTH    (PW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_drain_start  (drain_start),
    .i_psum_in      (psum_in),
    .o_shift_out    (shift_out),
    .i_wr_ready     (wr_ready),
    .o_wr_valid     (wr_valid),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_busy         (busy),
    .o_tile_done    (tile_done),
    .o_layer_done   (layer_done),
    .o_overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected RAM write addresses, in order
  int exp_q[$];
  int mon_a;

  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wr_unexpected: write to addr %0d, want no write", wr_addr);
      end else begin
        mon_a = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(mon_a));
        check_data("wr_data", wr_data, psum_in);
      end
    end else if (shift_out && !wr_valid) begin
      check_data("pad_wr_data", wr_data, '0);
    end
  end

  // Reference tile/fgroup counters
  int m_tile = 0;
  int m_fg   = 0;
  int chain_tile = 0;

  task automatic push_tile(output int t);
    for (int r = 0; r < int'(SS); r++) begin
      if (m_tile * int'(SS) + r < int'(OP)) exp_q.push_back(m_fg * int'(OP) + m_tile * int'(SS) + r);
    end
    t = m_tile;
    if (m_tile == NT - 1) begin
      m_tile = 0;
      m_fg   = (m_fg == NFG - 1) ? 0 : m_fg + 1;
    end else begin
      m_tile = m_tile + 1;
    end
  endtask

  task automatic run_drain(input int stall_row, input int stall_len, input bit pad_low,
                           input int exp_cycles, input bit exp_layer,
                           input int req_row, input int req2_row, input int start_row,
                           input bit chained);
    int row, stall, cycles, tile;
    bit done, f1, f2, fs, pend, rr;
    done = 0; f1 = 0; f2 = 0; fs = 0; pend = 0; stall = 0;
    if (chained) begin
      tile = chain_tile;
      row = 1;
      cycles = 1;
      @(posedge clk); #1;
    end else begin
      push_tile(tile);
      row = 0;
      cycles = 0;
      @(posedge clk); #1;
      drain_start = 1'b1;
      @(posedge clk); #1;
      drain_start = 1'b0;
    end
    for (int g = 0; g < 200 && !done; g++) begin
      rr = (row < int'(SS)) && (tile * int'(SS) + row < int'(OP));
      wr_ready = (row >= int'(SS)) ||
                 (!((row == stall_row) && (stall < stall_len)) && !(pad_low && !rr));
      drain_start = 1'b0;
      start = 1'b0;
      if (row == req_row && !f1) begin
        drain_start = 1'b1;
        f1 = 1;
        pend = 1;
        push_tile(chain_tile);
      end else if (row == req2_row && !f2) begin
        drain_start = 1'b1;
        f2 = 1;
      end
      if (row == start_row && !fs) begin
        start = 1'b1;
        fs = 1;
      end
      for (int k = 0; k < int'(DW / 32); k++) psum_in[k*32 +: 32] = $urandom();
      @(negedge clk);
      if (tile_done) begin
        done = 1;
      end else begin
        if (row < int'(SS)) begin
          check("shift_out", 64'(shift_out), 64'(wr_ready || !rr));
          check("wr_valid", 64'(wr_valid), 64'(rr));
        end
        cycles++;
        if (row >= int'(SS) || wr_ready || !rr) row++;
        else stall++;
        @(posedge clk); #1;
      end
    end
    drain_start = 1'b0;
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tile_done_timeout: no tile_done after %0d cycles, want %0d", cycles, exp_cycles);
    end else begin
      check("drain_cycles", 64'(cycles), 64'(exp_cycles));
      check("layer_done", 64'(layer_done), 64'(exp_layer));
      check("chain_shift", 64'(shift_out), 64'(pend));
      check("busy_after", 64'(busy), 64'(pend));
      if (!pend) check("sb_empty", 64'(exp_q.size()), 64'(0));
    end
  endtask

  typedef struct {
    int stall_row;
    int stall_len;
    bit pad_low;
    int exp_cycles;
    bit exp_layer;
  } vec_t;

  vec_t vecs[6];
  int   t_dummy;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // One full layer: (fg,tile) = (0,0) (0,1) (0,2) (1,0) (1,1) (1,2)
    vecs[0] = '{-1, 0, 1'b0, 16, 1'b0};
    vecs[1] = '{ 3, 5, 1'b0, 21, 1'b0};
    vecs[2] = '{-1, 0, 1'b1, 16, 1'b0};
    vecs[3] = '{ 0, 2, 1'b0, 18, 1'b0};
    vecs[4] = '{15, 1, 1'b0, 17, 1'b0};
    vecs[5] = '{ 7, 3, 1'b0, 19, 1'b1};

    rst = 1'b1; start = 1'b0; drain_start = 1'b0; wr_ready = 1'b0; psum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_shift_out", 64'(shift_out), 64'(0));
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tile_done", 64'(tile_done), 64'(0));
    check("rst_layer_done", 64'(layer_done), 64'(0));
    check("rst_overflow", 64'(overflow_err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_drain(vecs[i].stall_row, vecs[i].stall_len, vecs[i].pad_low,
                vecs[i].exp_cycles, vecs[i].exp_layer, -1, -1, -1, 1'b0);
    end

    // Back-to-back: queued request at row 7, overflowing one at row 10
    run_drain(-1, 0, 1'b0, 16, 1'b0, 7, 10, -1, 1'b0);
    check("overflow_set", 64'(overflow_err), 64'(1));
    run_drain(-1, 0, 1'b0, 16, 1'b0, -1, -1, -1, 1'b1);
    check("overflow_sticky", 64'(overflow_err), 64'(1));

    // start while busy must not disturb the counters
    run_drain(-1, 0, 1'b0, 16, 1'b0, -1, -1, 4, 1'b0);
    run_drain(-1, 0, 1'b0, 16, 1'b0, -1, -1, -1, 1'b0);

    // Reset in the middle of a tile
    push_tile(t_dummy);
    @(posedge clk); #1;
    drain_start = 1'b1;
    @(posedge clk); #1;
    drain_start = 1'b0;
    wr_ready = 1'b1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_shift_out", 64'(shift_out), 64'(0));
    check("mid_rst_wr_valid", 64'(wr_valid), 64'(0));
    check("mid_rst_wr_addr", 64'(wr_addr), 64'(0));
    check_data("mid_rst_wr_data", wr_data, '0);
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_tile_done", 64'(tile_done), 64'(0));
    check("mid_rst_overflow", 64'(overflow_err), 64'(0));
    exp_q.delete();
    m_tile = 0;
    m_fg = 0;
    run_drain(-1, 0, 1'b0, 16, 1'b0, -1, -1, -1, 1'b0);

    // start in IDLE rewinds to tile 0
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_tile = 0;
    m_fg = 0;
    run_drain(2, 1, 1'b0, 17, 1'b0, -1, -1, -1, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
